muldiv_seq: RTL and testbench

Iterative multi-cycle controller for the RV M-extension ops (mul/mulh/mulhsu/mulhu/div/divu/rem/remu) produced by the instruction decoder.
- Accepts one op at a time via valid/ready, runs a radix-2 shift-add multiply or restoring divide, applies sign and RISC-V special-case fixup, and returns the result via valid/ready.
- Sits beside the ALU in the execute stage. The core stalls on busy.

---
 rtl/muldiv_seq.sv | 155 +++++++++++++++
 tb/tb_muldiv_seq.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV M-extension unit: radix-2 shift-add multiply / restoring divide with sign and special-case fixup.
// Optional MULDIV_FAST_PATH_EN: divide-by-zero, signed overflow and zero mul operands skip the iterations.
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [7:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  localparam int AW = 2*XLEN + 1;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        op_q;
  logic [AW-1:0]     acc_q;
  logic [XLEN-1:0]   opnd_q;   // multiplicand or divisor magnitude
  logic [XLEN-1:0]   rs1_q;
  logic              neg_q, rsign_q, dz_q, ovf_q;

  // request decode
  logic            accept, onehot, is_mul, is_div, sa, sb, dz_in, ovf_in, fast_in;
  logic [XLEN-1:0] m1, m2;

  assign req_ready  = (state == S_IDLE) && !flush;
  assign accept     = req_valid && req_ready;
  assign busy       = (state != S_IDLE);
  assign resp_valid = (state == S_DONE);

  assign onehot = (req_op != 8'd0) && ((req_op & (req_op - 8'd1)) == 8'd0);
  assign is_mul = |req_op[3:0];
  assign is_div = |req_op[7:4];
  assign sa     = req_rs1[XLEN-1] & (req_op[1] | req_op[2] | req_op[4] | req_op[6]);
  assign sb     = req_rs2[XLEN-1] & (req_op[1] | req_op[4] | req_op[6]);
  assign m1     = sa ? -req_rs1 : req_rs1;
  assign m2     = sb ? -req_rs2 : req_rs2;
  assign dz_in  = is_div && (req_rs2 == '0);
  assign ovf_in = (req_op[4] | req_op[6]) && (req_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&req_rs2);

`ifdef MULDIV_FAST_PATH_EN
  assign fast_in = dz_in || ovf_in || (is_mul && ((req_rs1 == '0) || (req_rs2 == '0)));
`else
  assign fast_in = 1'b0;
`endif

  // FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) begin
        if (!onehot)     state_nxt = S_DONE;
        else if (fast_in) state_nxt = S_FIX;
        else if (is_mul)  state_nxt = S_MUL;
        else              state_nxt = S_DIV;
      end
      S_MUL, S_DIV: if (cnt == CNT_W'(XLEN-1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: if (resp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  // one iteration of each algorithm
  logic [XLEN:0]   mul_sum, div_trial;
  logic            div_ge;
  logic [AW-1:0]   mul_nxt, div_nxt;

  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
  assign mul_nxt   = acc_q[0] ? {1'b0, mul_sum, acc_q[XLEN-1:1]} : (acc_q >> 1);
  assign div_ge    = acc_q[AW-2:XLEN-1] >= {1'b0, opnd_q};
  assign div_trial = acc_q[AW-2:XLEN-1] - {1'b0, opnd_q};
  assign div_nxt   = div_ge ? {div_trial, acc_q[XLEN-2:0], 1'b1} : {acc_q[AW-2:0], 1'b0};

  // result selection and sign correction
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo, rem, fix_res;

  assign prod_s = neg_q ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
  assign quo    = acc_q[XLEN-1:0];
  assign rem    = acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fix_res = '0;
    if (op_q[0])
      fix_res = prod_s[XLEN-1:0];
    else if (|op_q[3:1])
      fix_res = prod_s[2*XLEN-1:XLEN];
    else if (op_q[4] || op_q[5])
      fix_res = dz_q ? '1 : (ovf_q ? rs1_q : (neg_q ? -quo : quo));
    else if (op_q[6] || op_q[7])
      fix_res = dz_q ? rs1_q : (ovf_q ? '0 : (rsign_q ? -rem : rem));
  end

  // datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      op_q      <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      rs1_q     <= '0;
      neg_q     <= 1'b0;
      rsign_q   <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      resp_data <= '0;
    end else if (accept) begin
      cnt     <= '0;
      op_q    <= req_op;
      rs1_q   <= req_rs1;
      neg_q   <= sa ^ sb;
      rsign_q <= sa;
      dz_q    <= dz_in;
      ovf_q   <= ovf_in;
      opnd_q  <= is_mul ? m1 : m2;
      // a fast-path mul has a zero operand, so a zero accumulator is the product
      if (fast_in)     acc_q <= '0;
      else if (is_mul) acc_q <= {{(XLEN+1){1'b0}}, m2};
      else             acc_q <= {{(XLEN+1){1'b0}}, m1};
      if (!onehot) resp_data <= '0;
    end else begin
      case (state)
        S_MUL: begin
          acc_q <= mul_nxt;
          cnt   <= cnt + 1'b1;
        end
        S_DIV: begin
          acc_q <= div_nxt;
          cnt   <= cnt + 1'b1;
        end
        S_FIX: if (!flush) resp_data <= fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq (XLEN=32); latency counted in clock edges from the accepting edge inclusive.
module tb_muldiv_seq;

  localparam int XLEN = 32;
  localparam int FULL = XLEN + 2;
`ifdef MULDIV_FAST_PATH_EN
  localparam int SPEC = 2;
`else
  localparam int SPEC = FULL;
`endif

  localparam logic [7:0] MUL = 8'h01, MULH = 8'h02, MULHSU = 8'h04, MULHU = 8'h08;
  localparam logic [7:0] DIV = 8'h10, DIVU = 8'h20, REM = 8'h40, REMU = 8'h80;

  logic            clk = 1'b0, rst = 1'b1;
  logic            req_valid = 1'b0, req_ready;
  logic [7:0]      req_op = '0;
  logic [XLEN-1:0] req_rs1 = '0, req_rs2 = '0;
  logic            flush = 1'b0;
  logic            resp_valid, resp_ready = 1'b0, busy;
  logic [XLEN-1:0] resp_data;

  int n_chk = 0, n_fail = 0;

  muldiv_seq #(.XLEN(XLEN), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // present a request at the negedge; return after the accepting edge (+1)
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    issue(op, a, b);
    wait_resp(n);
    chk({tag, " lat"}, 64'(n + 1), 64'(lat));
    chk({tag, " data"}, {32'd0, resp_data}, {32'd0, exp});
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, " drain"}, {63'd0, resp_valid}, 64'd0);
    @(negedge clk); resp_ready = 1'b0;
  endtask

  initial begin
    int n, seen;
    #12;
    chk("rst req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst resp_data", {32'd0, resp_data}, 64'd0);
    @(negedge clk); rst = 1'b0;

    run_op("mul", MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, FULL);
    run_op("mulhu", MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, FULL);
    run_op("mulh", MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, FULL);
    run_op("mulhsu", MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, FULL);
    run_op("div", DIV, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFA, FULL);
    run_op("rem", REM, 32'hFFFFFFEC, 32'd3, 32'hFFFFFFFE, FULL);
    run_op("divu", DIVU, 32'd100, 32'd7, 32'd14, FULL);
    run_op("remu", REMU, 32'd100, 32'd7, 32'd2, FULL);
    run_op("divu0", DIVU, 32'd100, 32'd0, 32'hFFFFFFFF, SPEC);
    run_op("remu0", REMU, 32'd100, 32'd0, 32'd100, SPEC);
    run_op("div ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPEC);
    run_op("rem ovf", REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, SPEC);
    run_op("mul zero", MUL, 32'd0, 32'd5, 32'd0, SPEC);
    run_op("mulh neg", MULH, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, FULL);
    run_op("rem neg", REM, 32'd20, 32'hFFFFFFFD, 32'd2, FULL);
    run_op("mul big", MUL, 32'd5, 32'd7, 32'd35, FULL);
    run_op("bad op", 8'h03, 32'd5, 32'd7, 32'd0, 1);

    // backpressure in DONE, with a competing request held on the bus
    issue(DIVU, 32'd100, 32'd7);
    wait_resp(n);
    chk("bp reached", {63'd0, resp_valid}, 64'd1);
    @(negedge clk);
    req_valid = 1'b1; req_op = MUL; req_rs1 = 32'd3; req_rs2 = 32'd4;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp valid", {63'd0, resp_valid}, 64'd1);
      chk("bp data", {32'd0, resp_data}, 64'd14);
      chk("bp req_ready", {63'd0, req_ready}, 64'd0);
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp idle busy", {63'd0, busy}, 64'd0);
    chk("bp idle ready", {63'd0, req_ready}, 64'd1);
    @(negedge clk); resp_ready = 1'b0;
    @(posedge clk); #1;
    chk("bp accept", {63'd0, busy}, 64'd1);
    req_valid = 1'b0;
    wait_resp(n);
    chk("bp next lat", 64'(n + 1), 64'(FULL));
    chk("bp next data", {32'd0, resp_data}, 64'd12);
    @(negedge clk); resp_ready = 1'b1;
    @(negedge clk); resp_ready = 1'b0;

    // flush at iteration 10 of a div, with a same-cycle request
    issue(DIV, 32'hFFFFFFEC, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_op = MUL; req_rs1 = 32'd9; req_rs2 = 32'd9;
    #1 chk("flush req_ready", {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    chk("flush busy", {63'd0, busy}, 64'd0);
    chk("flush resp_valid", {63'd0, resp_valid}, 64'd0);
    @(negedge clk); flush = 1'b0; req_valid = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (resp_valid || busy) seen++; end
    chk("flush quiet", 64'(seen), 64'd0);
    run_op("post flush", MUL, 32'd3, 32'd4, 32'd12, FULL);

    // asynchronous reset in the middle of a multiply
    issue(MUL, 32'd7, 32'd9);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst busy", {63'd0, busy}, 64'd0);
    chk("arst req_ready", {63'd0, req_ready}, 64'd1);
    chk("arst resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("arst resp_data", {32'd0, resp_data}, 64'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (resp_valid) seen++; end
    chk("arst no resp", 64'(seen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
